rr_arbiter8: RTL and testbench

Eight-way round-robin arbiter that shares one decoded select resource among eight requesters. It registers a 3-bit grant index and its one-hot decode (3-to-8 form, enable-gated) for the shared datapath. It bounds each grant with a hold limit. It sits between the requesting units and the decoder-selected resource, and is the only block that drives the select lines.

---
 rtl/rr_arbiter8_if.sv | 11 +
 rtl/rr_arbiter8.sv | 66 ++++++
 tb/tb_rr_arbiter8.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between requesters and the round-robin arbiter
interface rr_arbiter8_if;
  logic       E;
  logic [7:0] req;
  logic [2:0] A;
  logic [7:0] Y;
  logic       V;
  logic       expired;
  modport master (output E, req, input A, Y, V, expired);
  modport slave (input E, req, output A, Y, V, expired);
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with registered index/one-hot grant and hold limit
module rr_arbiter8 #(
  parameter int HOLD_MAX = 15
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter8_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state, state_n;
  logic [2:0] ptr, ptr_n, pick, a_n;
  logic [7:0] cnt, cnt_n;
  logic       v_n, exp_n, rel;
  // first requester at or after ptr; descending scan lets the nearest offset win
  always_comb begin
    pick = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (bus.req[ptr + 3'(i)]) pick = ptr + 3'(i);
  end
  // next state, pointer, counter and output values
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    a_n     = bus.A;
    v_n     = bus.V;
    exp_n   = 1'b0;
    rel     = !bus.req[bus.A] || !bus.E || cnt == 8'(HOLD_MAX - 1);
    if (state == IDLE) begin
      v_n = bus.E && |bus.req;
      if (v_n) begin
        a_n     = pick;
        cnt_n   = 8'd0;
        state_n = GRANT;
      end
    end else if (rel) begin
      v_n     = 1'b0;
      ptr_n   = bus.A + 3'd1;
      cnt_n   = 8'd0;
      exp_n   = bus.req[bus.A] && bus.E;
      state_n = IDLE;
    end else begin
      cnt_n = cnt + 8'd1;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      cnt         <= 8'd0;
      bus.A       <= 3'd0;
      bus.Y       <= 8'h00;
      bus.V       <= 1'b0;
      bus.expired <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      bus.A       <= a_n;
      bus.Y       <= v_n ? 8'h01 << a_n : 8'h00;
      bus.V       <= v_n;
      bus.expired <= exp_n;
    end
  end
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed checks of the round-robin arbiter (HOLD_MAX 15 and 4)
module tb_rr_arbiter8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  rr_arbiter8_if a ();
  rr_arbiter8_if b ();
  rr_arbiter8 #(.HOLD_MAX(15)) dut (.clk(clk), .rst(rst), .bus(a.slave));
  rr_arbiter8 #(.HOLD_MAX(4)) dut4 (.clk(clk), .rst(rst), .bus(b.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a(input string tag, input logic v, input logic [2:0] idx, input logic [7:0] y, input logic ex);
    chk({tag, ".V"}, 32'(a.V), 32'(v));
    chk({tag, ".A"}, 32'(a.A), 32'(idx));
    chk({tag, ".Y"}, 32'(a.Y), 32'(y));
    chk({tag, ".expired"}, 32'(a.expired), 32'(ex));
  endtask
  task automatic chk_b(input string tag, input logic v, input logic [2:0] idx, input logic [7:0] y, input logic ex);
    chk({tag, ".V"}, 32'(b.V), 32'(v));
    chk({tag, ".A"}, 32'(b.A), 32'(idx));
    chk({tag, ".Y"}, 32'(b.Y), 32'(y));
    chk({tag, ".expired"}, 32'(b.expired), 32'(ex));
  endtask
  initial begin
    a.E = 1'b0; a.req = 8'h00;
    b.E = 1'b0; b.req = 8'h00;
    step();
    step();
    chk_a("reset", 0, 3'd0, 8'h00, 0);
    chk_b("reset4", 0, 3'd0, 8'h00, 0);
    rst = 1'b0;
    a.req = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_a("disabled", 0, 3'd0, 8'h00, 0);
    end
    a.E = 1'b1; a.req = 8'h04;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a("single", 1, 3'd2, 8'h04, 0);
    end
    a.req = 8'h00;
    step();
    chk_a("single_rel", 0, 3'd2, 8'h00, 0);
    a.req = 8'h0C;
    step();
    chk_a("ptr3", 1, 3'd3, 8'h08, 0);
    a.req = 8'h00;
    step();
    chk_a("ptr3_rel", 0, 3'd3, 8'h00, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    a.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      chk_a("rotate", 1, 3'(k % 8), 8'h01 << (k % 8), 0);
      a.req = 8'hFF & ~(8'h01 << (k % 8));
      step();
      chk_a("rotate_gap", 0, 3'(k % 8), 8'h00, 0);
      a.req = 8'hFF;
    end
    a.req = 8'h10;
    step();
    chk_a("grant4", 1, 3'd4, 8'h10, 0);
    a.req = 8'h00;
    step();
    a.req = 8'h09;
    step();
    chk_a("past_ptr", 1, 3'd0, 8'h01, 0);
    a.req = 8'h08;
    step();
    chk_a("past_ptr_rel", 0, 3'd0, 8'h00, 0);
    step();
    chk_a("then3", 1, 3'd3, 8'h08, 0);
    a.req = 8'h00;
    step();
    a.req = 8'h02;
    step();
    chk_a("grant1", 1, 3'd1, 8'h02, 0);
    a.E = 1'b0;
    step();
    chk_a("e_off_rel", 0, 3'd1, 8'h00, 0);
    step();
    chk_a("e_off_idle", 0, 3'd1, 8'h00, 0);
    a.E = 1'b1;
    b.E = 1'b1; b.req = 8'h10;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_b("hold", 1, 3'd4, 8'h10, 0);
    end
    step();
    chk_b("hold_expire", 0, 3'd4, 8'h00, 1);
    step();
    chk_b("hold_regrant", 1, 3'd4, 8'h10, 0);
    for (int i = 0; i < 3; i++) step();
    chk_b("hold_last", 1, 3'd4, 8'h10, 0);
    b.req = 8'h00;
    step();
    chk_b("hold_drop", 0, 3'd4, 8'h00, 0);
    a.req = 8'h40;
    step();
    step();
    chk_a("grant6", 1, 3'd6, 8'h40, 0);
    rst = 1'b1;
    step();
    chk_a("mid_reset", 0, 3'd0, 8'h00, 0);
    rst = 1'b0;
    step();
    chk_a("after_reset", 1, 3'd6, 8'h40, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
